// File: rtl/mul_wb_queue.sv
// mul_wb_queue
// Writeback collector that sits after the 5-stage multiplier. It buffers
// multiplier results in a small FIFO and writes them into the shared
// register-file port in cycles where the main pipeline leaves that port idle.
//
// Ports:
//   clk, reset        clock (rising edge), asynchronous active-low reset
//   mul_issue_i       multiply accepted into multiplier stage 1 (takes a credit)
//   issue_ready_o     a credit is available for another multiply
//   mul_valid_i       multiplier result valid (returns a credit)
//   mul_res_i         64-bit multiplier result
//   mul_rd_addr_i     destination register
//   mul_rd_wr_en_i    destination write enable
//   wb_port_busy_i    main pipeline owns the register-file write port this cycle
//   wb_valid_o        queue writes the register file this cycle
//   wb_rd_addr_o      write address (head entry, 0 when empty)
//   wb_data_o         write data (head entry, 0 when empty)
//   hold_main_o       asks the main pipeline to free the write port next cycle
//   hz_rs1_i/hz_rs2_i source registers to check against pending writes
//   hazard_o          a queued or incoming entry targets hz_rs1_i/hz_rs2_i
//   overflow_err_o    sticky: a result arrived while the FIFO was full
module mul_wb_queue #(
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mul_issue_i,
  output logic        issue_ready_o,
  input  logic        mul_valid_i,
  input  logic [63:0] mul_res_i,
  input  logic [4:0]  mul_rd_addr_i,
  input  logic        mul_rd_wr_en_i,
  input  logic        wb_port_busy_i,
  output logic        wb_valid_o,
  output logic [4:0]  wb_rd_addr_o,
  output logic [63:0] wb_data_o,
  output logic        hold_main_o,
  input  logic [4:0]  hz_rs1_i,
  input  logic [4:0]  hz_rs2_i,
  output logic        hazard_o,
  output logic        overflow_err_o
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  localparam logic [CW-1:0] OCC_FULL   = CW'(DEPTH);
  localparam logic [CW:0]   CREDIT_LIM = (CW+1)'(DEPTH);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);
  localparam logic [SW-1:0] STARVE_TH  = SW'(STARVE_LIMIT - 1);

  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_occ;
  logic [CW-1:0] r_inflight;
  logic [SW-1:0] r_starve;
  logic          r_hold;
  logic          r_overflow;
  logic [DEPTH-1:0] r_vld;
  logic [4:0]    r_addr [DEPTH];
  logic [63:0]   r_data [DEPTH];

  logic          w_empty;
  logic          w_full;
  logic          w_enq_req;
  logic          w_pop;
  logic          w_enq;
  logic          w_ovf;
  logic [CW:0]   w_credit_sum;
  logic [CW-1:0] w_occ_nxt;
  logic [SW-1:0] w_starve_nxt;
  logic          w_hold_nxt;
  logic          w_hazard;

  function automatic logic f_hit(input logic [4:0] a, input logic [4:0] rs1,
                                 input logic [4:0] rs2);
    f_hit = ((rs1 != 5'd0) && (a == rs1)) || ((rs2 != 5'd0) && (a == rs2));
  endfunction

  assign w_empty   = (r_occ == '0);
  assign w_full    = (r_occ == OCC_FULL);
  // Results without a real destination are dropped but still return a credit.
  assign w_enq_req = mul_valid_i && mul_rd_wr_en_i && (mul_rd_addr_i != 5'd0);
  assign w_pop     = !w_empty && !wb_port_busy_i;
  // A full FIFO still accepts when the head leaves in the same cycle.
  assign w_enq     = w_enq_req && (!w_full || w_pop);
  assign w_ovf     = w_enq_req && w_full && !w_pop;

  // Credits count both buffered entries and multiplies still in the pipe.
  assign w_credit_sum  = {1'b0, r_occ} + {1'b0, r_inflight};
  assign issue_ready_o = (w_credit_sum < CREDIT_LIM);

  assign wb_valid_o     = w_pop;
  assign wb_rd_addr_o   = w_empty ? 5'd0  : r_addr[r_rd_ptr];
  assign wb_data_o      = w_empty ? 64'd0 : r_data[r_rd_ptr];
  assign hold_main_o    = r_hold;
  assign hazard_o       = w_hazard;
  assign overflow_err_o = r_overflow;

  always_comb begin
    w_occ_nxt = r_occ;
    if (w_enq && !w_pop) begin
      w_occ_nxt = r_occ + CW'(1);
    end else if (!w_enq && w_pop) begin
      w_occ_nxt = r_occ - CW'(1);
    end
  end

  // The starve counter tracks consecutive blocked cycles; hold is evaluated
  // on the next-state values so it lines up with the counter it depends on.
  always_comb begin
    w_starve_nxt = r_starve;
    if (w_empty || w_pop) begin
      w_starve_nxt = '0;
    end else if (wb_port_busy_i && (r_starve != STARVE_MAX)) begin
      w_starve_nxt = r_starve + SW'(1);
    end
    w_hold_nxt = (w_occ_nxt != '0) && (w_starve_nxt >= STARVE_TH);
  end

  // The incoming result counts as pending as soon as it will be enqueued.
  always_comb begin
    w_hazard = w_enq && f_hit(mul_rd_addr_i, hz_rs1_i, hz_rs2_i);
    for (int i = 0; i < DEPTH; i++) begin
      if (r_vld[i] && f_hit(r_addr[i], hz_rs1_i, hz_rs2_i)) begin
        w_hazard = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_occ      <= '0;
      r_inflight <= '0;
      r_starve   <= '0;
      r_hold     <= 1'b0;
      r_overflow <= 1'b0;
      r_vld      <= '0;
    end else begin
      r_occ    <= w_occ_nxt;
      r_starve <= w_starve_nxt;
      r_hold   <= w_hold_nxt;
      if (w_ovf) begin
        r_overflow <= 1'b1;
      end
      if (w_pop) begin
        r_vld[r_rd_ptr] <= 1'b0;
        r_rd_ptr        <= r_rd_ptr + PW'(1);
      end
      // Set after clear: on full-with-pop the write and read slots coincide.
      if (w_enq) begin
        r_vld[r_wr_ptr] <= 1'b1;
        r_wr_ptr        <= r_wr_ptr + PW'(1);
      end
      // Saturating so a stray valid or issue cannot wrap the credit count.
      if (mul_issue_i && !mul_valid_i && (r_inflight != OCC_FULL)) begin
        r_inflight <= r_inflight + CW'(1);
      end else if (mul_valid_i && !mul_issue_i && (r_inflight != '0)) begin
        r_inflight <= r_inflight - CW'(1);
      end
    end
  end

  // Payload storage needs no reset; entries are qualified by occupancy.
  always_ff @(posedge clk) begin
    if (w_enq) begin
      r_addr[r_wr_ptr] <= mul_rd_addr_i;
      r_data[r_wr_ptr] <= mul_res_i;
    end
  end

endmodule

// File: tb/tb_mul_wb_queue.sv
// tb_mul_wb_queue
// Self-checking bench for mul_wb_queue. Directed scenarios check fixed
// expectations; a randomized run compares every cycle against a queue-based
// behavioural model of the writeback collector.
module tb_mul_wb_queue;

  localparam int DEPTH        = 4;
  localparam int STARVE_LIMIT = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        mul_issue_i = 1'b0;
  logic        issue_ready_o;
  logic        mul_valid_i = 1'b0;
  logic [63:0] mul_res_i = 64'd0;
  logic [4:0]  mul_rd_addr_i = 5'd0;
  logic        mul_rd_wr_en_i = 1'b0;
  logic        wb_port_busy_i = 1'b0;
  logic        wb_valid_o;
  logic [4:0]  wb_rd_addr_o;
  logic [63:0] wb_data_o;
  logic        hold_main_o;
  logic [4:0]  hz_rs1_i = 5'd0;
  logic [4:0]  hz_rs2_i = 5'd0;
  logic        hazard_o;
  logic        overflow_err_o;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [4:0]  rd;
    logic [63:0] data;
  } ent_t;

  ent_t m_q[$];
  int   m_inflight = 0;
  int   m_run = 0;
  bit   m_ovf = 1'b0;

  always #5 clk = ~clk;

  mul_wb_queue #(.DEPTH(DEPTH), .STARVE_LIMIT(STARVE_LIMIT)) dut (
    .clk            (clk),
    .reset          (reset),
    .mul_issue_i    (mul_issue_i),
    .issue_ready_o  (issue_ready_o),
    .mul_valid_i    (mul_valid_i),
    .mul_res_i      (mul_res_i),
    .mul_rd_addr_i  (mul_rd_addr_i),
    .mul_rd_wr_en_i (mul_rd_wr_en_i),
    .wb_port_busy_i (wb_port_busy_i),
    .wb_valid_o     (wb_valid_o),
    .wb_rd_addr_o   (wb_rd_addr_o),
    .wb_data_o      (wb_data_o),
    .hold_main_o    (hold_main_o),
    .hz_rs1_i       (hz_rs1_i),
    .hz_rs2_i       (hz_rs2_i),
    .hazard_o       (hazard_o),
    .overflow_err_o (overflow_err_o)
  );

  // Model predictions, written from the behavioural rules of the block.
  function automatic bit exp_ready();
    return (m_q.size() + m_inflight) < DEPTH;
  endfunction

  function automatic bit exp_wb_valid();
    return (m_q.size() != 0) && !wb_port_busy_i;
  endfunction

  function automatic logic [4:0] exp_addr();
    return (m_q.size() != 0) ? m_q[0].rd : 5'd0;
  endfunction

  function automatic logic [63:0] exp_data();
    return (m_q.size() != 0) ? m_q[0].data : 64'd0;
  endfunction

  function automatic bit exp_hold();
    return (m_q.size() != 0) && (m_run >= STARVE_LIMIT - 1);
  endfunction

  function automatic bit exp_hazard();
    bit hit;
    bit enq;
    hit = 1'b0;
    foreach (m_q[i]) begin
      if ((hz_rs1_i != 0 && m_q[i].rd == hz_rs1_i) || (hz_rs2_i != 0 && m_q[i].rd == hz_rs2_i))
        hit = 1'b1;
    end
    enq = mul_valid_i && mul_rd_wr_en_i && (mul_rd_addr_i != 0) &&
          ((m_q.size() < DEPTH) || ((m_q.size() != 0) && !wb_port_busy_i));
    if (enq && ((hz_rs1_i != 0 && mul_rd_addr_i == hz_rs1_i) ||
                (hz_rs2_i != 0 && mul_rd_addr_i == hz_rs2_i)))
      hit = 1'b1;
    return hit;
  endfunction

  task automatic settle();
    #1;
  endtask

  task automatic drive_idle();
    mul_issue_i    = 1'b0;
    mul_valid_i    = 1'b0;
    mul_res_i      = 64'd0;
    mul_rd_addr_i  = 5'd0;
    mul_rd_wr_en_i = 1'b0;
    wb_port_busy_i = 1'b0;
    hz_rs1_i       = 5'd0;
    hz_rs2_i       = 5'd0;
  endtask

  task automatic set_result(input logic [4:0] rd, input logic [63:0] data, input logic wr_en);
    mul_valid_i    = 1'b1;
    mul_rd_addr_i  = rd;
    mul_res_i      = data;
    mul_rd_wr_en_i = wr_en;
  endtask

  // Advance one clock and update the model from the inputs seen at the edge.
  task automatic tick();
    bit was_empty;
    bit pop;
    bit enq_req;
    bit full;
    ent_t e;
    was_empty = (m_q.size() == 0);
    pop       = !was_empty && !wb_port_busy_i;
    enq_req   = mul_valid_i && mul_rd_wr_en_i && (mul_rd_addr_i != 0);
    full      = (m_q.size() == DEPTH);
    e.rd      = mul_rd_addr_i;
    e.data    = mul_res_i;
    @(posedge clk);
    if (pop) m_q.delete(0);
    if (enq_req) begin
      if (!full || pop) m_q.push_back(e);
      else m_ovf = 1'b1;
    end
    if (mul_issue_i && !mul_valid_i && m_inflight < DEPTH) m_inflight++;
    else if (mul_valid_i && !mul_issue_i && m_inflight > 0) m_inflight--;
    if (pop || was_empty) m_run = 0;
    else if (wb_port_busy_i) m_run++;
    #1;
  endtask

  // Finish a reset that is already asserted: clear model, release cleanly.
  task automatic finish_reset();
    drive_idle();
    m_q.delete();
    m_inflight = 0;
    m_run      = 0;
    m_ovf      = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  task automatic test_reset();
    #2;
    reset = 1'b0;
    #1;
    checks++; if (wb_valid_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_wb_valid: got %b expected 0", wb_valid_o); end
    checks++; if (hold_main_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_hold: got %b expected 0", hold_main_o); end
    checks++; if (hazard_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_hazard: got %b expected 0", hazard_o); end
    checks++; if (overflow_err_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_overflow: got %b expected 0", overflow_err_o); end
    checks++; if (wb_rd_addr_o !== 5'd0 || wb_data_o !== 64'd0) begin errors++; $display("[TB] FAIL reset_wb_bus: got %h/%h expected 0/0", wb_rd_addr_o, wb_data_o); end
    finish_reset();
    settle();
    checks++; if (issue_ready_o !== 1'b1) begin errors++; $display("[TB] FAIL reset_ready: got %b expected 1", issue_ready_o); end
  endtask

  task automatic test_single();
    mul_issue_i = 1'b1;
    settle();
    checks++; if (issue_ready_o !== 1'b1) begin errors++; $display("[TB] FAIL single_ready_issue: got %b expected 1", issue_ready_o); end
    tick();
    mul_issue_i = 1'b0;
    repeat (4) tick();
    set_result(5'd5, 64'h1234, 1'b1);
    settle();
    checks++; if (wb_valid_o !== 1'b0) begin errors++; $display("[TB] FAIL single_no_bypass: got %b expected 0", wb_valid_o); end
    checks++; if (issue_ready_o !== 1'b1) begin errors++; $display("[TB] FAIL single_ready_result: got %b expected 1", issue_ready_o); end
    tick();
    drive_idle();
    settle();
    checks++; if (wb_valid_o !== 1'b1) begin errors++; $display("[TB] FAIL single_wb_valid: got %b expected 1", wb_valid_o); end
    checks++; if (wb_rd_addr_o !== 5'd5) begin errors++; $display("[TB] FAIL single_wb_addr: got %0d expected 5", wb_rd_addr_o); end
    checks++; if (wb_data_o !== 64'h1234) begin errors++; $display("[TB] FAIL single_wb_data: got %h expected 1234", wb_data_o); end
    checks++; if (issue_ready_o !== 1'b1) begin errors++; $display("[TB] FAIL single_ready_wb: got %b expected 1", issue_ready_o); end
    tick();
    settle();
    checks++; if (wb_valid_o !== 1'b0) begin errors++; $display("[TB] FAIL single_drained: got %b expected 0", wb_valid_o); end
  endtask

  task automatic test_back_to_back();
    logic [63:0] d [4];
    wb_port_busy_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      mul_issue_i = 1'b1;
      settle();
      checks++; if (issue_ready_o !== 1'b1) begin errors++; $display("[TB] FAIL b2b_ready_before_%0d: got %b expected 1", i, issue_ready_o); end
      tick();
    end
    mul_issue_i = 1'b0;
    settle();
    checks++; if (issue_ready_o !== 1'b0) begin errors++; $display("[TB] FAIL b2b_ready_full: got %b expected 0", issue_ready_o); end
    for (int i = 0; i < 4; i++) begin
      d[i] = {$urandom, $urandom};
      set_result(5'(10 + i), d[i], 1'b1);
      tick();
      settle();
      checks++; if (wb_valid_o !== 1'b0 || issue_ready_o !== 1'b0) begin errors++; $display("[TB] FAIL b2b_busy_%0d: got valid=%b ready=%b expected 0/0", i, wb_valid_o, issue_ready_o); end
    end
    mul_valid_i = 1'b0;
    settle();
    checks++; if (wb_rd_addr_o !== 5'd10) begin errors++; $display("[TB] FAIL b2b_head_held: got %0d expected 10", wb_rd_addr_o); end
    wb_port_busy_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      settle();
      checks++; if (wb_valid_o !== 1'b1 || wb_rd_addr_o !== 5'(10 + i) || wb_data_o !== d[i]) begin
        errors++; $display("[TB] FAIL b2b_pop_%0d: got v=%b rd=%0d d=%h expected 1/%0d/%h", i, wb_valid_o, wb_rd_addr_o, wb_data_o, 10 + i, d[i]);
      end
      tick();
      if (i == 0) begin
        settle();
        checks++; if (issue_ready_o !== 1'b1) begin errors++; $display("[TB] FAIL b2b_ready_after_pop: got %b expected 1", issue_ready_o); end
      end
    end
    settle();
    checks++; if (wb_valid_o !== 1'b0) begin errors++; $display("[TB] FAIL b2b_empty: got %b expected 0", wb_valid_o); end
  endtask

  task automatic test_drop();
    mul_issue_i = 1'b1;
    repeat (2) tick();
    mul_issue_i = 1'b0;
    set_result(5'd0, 64'hdead, 1'b1);
    settle();
    tick();
    set_result(5'd6, 64'hbeef, 1'b0);
    hz_rs1_i = 5'd6;
    settle();
    checks++; if (hazard_o !== 1'b0) begin errors++; $display("[TB] FAIL drop_hazard: got %b expected 0", hazard_o); end
    tick();
    drive_idle();
    settle();
    checks++; if (wb_valid_o !== 1'b0) begin errors++; $display("[TB] FAIL drop_wb_valid: got %b expected 0", wb_valid_o); end
    mul_issue_i = 1'b1;
    repeat (3) tick();
    settle();
    checks++; if (issue_ready_o !== 1'b1) begin errors++; $display("[TB] FAIL drop_credit_returned: got %b expected 1", issue_ready_o); end
    tick();
    mul_issue_i = 1'b0;
    settle();
    checks++; if (issue_ready_o !== 1'b0) begin errors++; $display("[TB] FAIL drop_credit_exhausted: got %b expected 0", issue_ready_o); end
    set_result(5'd0, 64'd0, 1'b0);
    repeat (4) tick();
    drive_idle();
    settle();
    checks++; if (issue_ready_o !== 1'b1 || wb_valid_o !== 1'b0) begin errors++; $display("[TB] FAIL drop_final: got ready=%b valid=%b expected 1/0", issue_ready_o, wb_valid_o); end
  endtask

  task automatic test_starvation();
    wb_port_busy_i = 1'b1;
    mul_issue_i = 1'b1;
    tick();
    mul_issue_i = 1'b0;
    set_result(5'd7, 64'h77, 1'b1);
    tick();
    mul_valid_i = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      settle();
      checks++; if (hold_main_o !== (k >= STARVE_LIMIT) || wb_valid_o !== 1'b0) begin
        errors++; $display("[TB] FAIL starve_blocked_%0d: got hold=%b valid=%b expected %b/0", k, hold_main_o, wb_valid_o, k >= STARVE_LIMIT);
      end
      tick();
    end
    wb_port_busy_i = 1'b0;
    settle();
    checks++; if (wb_valid_o !== 1'b1 || wb_rd_addr_o !== 5'd7 || hold_main_o !== 1'b1) begin
      errors++; $display("[TB] FAIL starve_pop: got v=%b rd=%0d hold=%b expected 1/7/1", wb_valid_o, wb_rd_addr_o, hold_main_o);
    end
    tick();
    settle();
    checks++; if (hold_main_o !== 1'b0 || wb_valid_o !== 1'b0) begin errors++; $display("[TB] FAIL starve_release: got hold=%b valid=%b expected 0/0", hold_main_o, wb_valid_o); end
  endtask

  task automatic test_hazard();
    mul_issue_i = 1'b1;
    repeat (2) tick();
    mul_issue_i = 1'b0;
    wb_port_busy_i = 1'b1;
    set_result(5'd9, 64'h99, 1'b1);
    tick();
    mul_valid_i = 1'b0;
    hz_rs1_i = 5'd9; hz_rs2_i = 5'd0; settle();
    checks++; if (hazard_o !== 1'b1) begin errors++; $display("[TB] FAIL hz_rs1_hit: got %b expected 1", hazard_o); end
    hz_rs1_i = 5'd3; hz_rs2_i = 5'd0; settle();
    checks++; if (hazard_o !== 1'b0) begin errors++; $display("[TB] FAIL hz_no_hit: got %b expected 0", hazard_o); end
    hz_rs1_i = 5'd0; hz_rs2_i = 5'd9; settle();
    checks++; if (hazard_o !== 1'b1) begin errors++; $display("[TB] FAIL hz_rs2_hit: got %b expected 1", hazard_o); end
    set_result(5'd12, 64'hc, 1'b1);
    hz_rs1_i = 5'd12; hz_rs2_i = 5'd0; settle();
    checks++; if (hazard_o !== 1'b1) begin errors++; $display("[TB] FAIL hz_incoming: got %b expected 1", hazard_o); end
    tick();
    mul_valid_i = 1'b0;
    wb_port_busy_i = 1'b0;
    hz_rs1_i = 5'd9; settle();
    checks++; if (hazard_o !== 1'b1 || wb_rd_addr_o !== 5'd9) begin errors++; $display("[TB] FAIL hz_pop_cycle: got hz=%b rd=%0d expected 1/9", hazard_o, wb_rd_addr_o); end
    tick();
    settle();
    checks++; if (hazard_o !== 1'b0) begin errors++; $display("[TB] FAIL hz_after_wb: got %b expected 0", hazard_o); end
    tick();
    drive_idle();
  endtask

  task automatic test_overflow();
    wb_port_busy_i = 1'b1;
    mul_issue_i = 1'b1;
    repeat (4) tick();
    mul_issue_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      set_result(5'(20 + i), 64'(100 + i), 1'b1);
      tick();
    end
    wb_port_busy_i = 1'b0;
    set_result(5'd24, 64'd124, 1'b1);
    settle();
    checks++; if (wb_valid_o !== 1'b1 || wb_rd_addr_o !== 5'd20) begin errors++; $display("[TB] FAIL ovf_full_pop: got v=%b rd=%0d expected 1/20", wb_valid_o, wb_rd_addr_o); end
    tick();
    wb_port_busy_i = 1'b1;
    set_result(5'd25, 64'd125, 1'b1);
    settle();
    checks++; if (overflow_err_o !== 1'b0) begin errors++; $display("[TB] FAIL ovf_accept_with_pop: got %b expected 0", overflow_err_o); end
    tick();
    mul_valid_i = 1'b0;
    for (int k = 0; k < 3; k++) begin
      settle();
      checks++; if (overflow_err_o !== 1'b1 || wb_rd_addr_o !== 5'd21) begin
        errors++; $display("[TB] FAIL ovf_sticky_%0d: got ovf=%b head=%0d expected 1/21", k, overflow_err_o, wb_rd_addr_o);
      end
      tick();
    end
    wb_port_busy_i = 1'b0;
    settle();
    checks++; if (wb_rd_addr_o !== 5'd21 || wb_data_o !== 64'd101) begin errors++; $display("[TB] FAIL ovf_order_21: got rd=%0d d=%0d expected 21/101", wb_rd_addr_o, wb_data_o); end
    tick();
    settle();
    checks++; if (wb_rd_addr_o !== 5'd22 || overflow_err_o !== 1'b1) begin errors++; $display("[TB] FAIL ovf_order_22: got rd=%0d ovf=%b expected 22/1", wb_rd_addr_o, overflow_err_o); end
    wb_port_busy_i = 1'b1;
    set_result(5'd26, 64'd126, 1'b1);
    hz_rs1_i = 5'd23;
    reset = 1'b0;
    #1;
    checks++; if (wb_valid_o !== 1'b0 || wb_rd_addr_o !== 5'd0 || wb_data_o !== 64'd0) begin
      errors++; $display("[TB] FAIL midreset_wb: got v=%b rd=%0d d=%h expected 0/0/0", wb_valid_o, wb_rd_addr_o, wb_data_o);
    end
    checks++; if (hold_main_o !== 1'b0 || hazard_o !== 1'b0 || overflow_err_o !== 1'b0) begin
      errors++; $display("[TB] FAIL midreset_flags: got hold=%b hz=%b ovf=%b expected 0/0/0", hold_main_o, hazard_o, overflow_err_o);
    end
    finish_reset();
    settle();
    checks++; if (issue_ready_o !== 1'b1 || wb_valid_o !== 1'b0) begin errors++; $display("[TB] FAIL midreset_after: got ready=%b valid=%b expected 1/0", issue_ready_o, wb_valid_o); end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      mul_issue_i    = exp_ready() && ($urandom_range(0, 1) == 1);
      mul_valid_i    = (m_inflight > 0) && ($urandom_range(0, 2) != 0);
      mul_rd_addr_i  = 5'($urandom_range(0, 31));
      mul_rd_wr_en_i = ($urandom_range(0, 7) != 0);
      mul_res_i      = {$urandom, $urandom};
      if ($urandom_range(0, 3) == 0) wb_port_busy_i = ~wb_port_busy_i;
      hz_rs1_i       = 5'($urandom_range(0, 31));
      hz_rs2_i       = 5'($urandom_range(0, 31));
      settle();
      checks++; if (issue_ready_o !== exp_ready()) begin errors++; $display("[TB] FAIL rnd_ready@%0d: got %b expected %b", c, issue_ready_o, exp_ready()); end
      checks++; if (wb_valid_o !== exp_wb_valid()) begin errors++; $display("[TB] FAIL rnd_wb_valid@%0d: got %b expected %b", c, wb_valid_o, exp_wb_valid()); end
      checks++; if (wb_rd_addr_o !== exp_addr()) begin errors++; $display("[TB] FAIL rnd_wb_addr@%0d: got %0d expected %0d", c, wb_rd_addr_o, exp_addr()); end
      checks++; if (wb_data_o !== exp_data()) begin errors++; $display("[TB] FAIL rnd_wb_data@%0d: got %h expected %h", c, wb_data_o, exp_data()); end
      checks++; if (hold_main_o !== exp_hold()) begin errors++; $display("[TB] FAIL rnd_hold@%0d: got %b expected %b", c, hold_main_o, exp_hold()); end
      checks++; if (hazard_o !== exp_hazard()) begin errors++; $display("[TB] FAIL rnd_hazard@%0d: got %b expected %b", c, hazard_o, exp_hazard()); end
      checks++; if (overflow_err_o !== m_ovf) begin errors++; $display("[TB] FAIL rnd_overflow@%0d: got %b expected %b", c, overflow_err_o, m_ovf); end
      tick();
    end
    drive_idle();
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_drop();
    test_starvation();
    test_hazard();
    test_overflow();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
